// File: rtl/etapa_ex.sv
// -----------------------------------------------------------------------------
// etapa_ex -- execute stage of the pipelined MIPS core.
//
// Sits directly after the ID/EX pipeline register. Decodes the ALU operation
// from AluOP/funct, computes the result, selects the destination register and
// registers everything into the EX/MEM boundary. Also holds a 32-cycle
// iterative unsigned multiply/divide unit with its HI/LO registers. While that
// unit is busy, any instruction that needs it raises a combinational stall.
//
// Ports:
//   clk, rst_n           pipeline clock; asynchronous active-low reset
//   valid_in             ID/EX holds a real instruction (0 = bubble)
//   AluOP, funct         operation select (funct is used when AluOP = 010)
//   RegDsr               destination select: 1 = rd, 0 = rt
//   RegWrite             instruction writes the register file
//   data1, data2         operands A (rs) and B (rt or immediate)
//   store_data           rt value carried through for stores
//   rt, rd               candidate destination register indices
//   stall_out            freezes PC, IF/ID and ID/EX (combinational)
//   valid_out            EX/MEM holds a real instruction
//   resultado            ALU / HI / LO result
//   store_out            registered store_data
//   reg_destino          selected destination register
//   RegWrite_out         qualified, registered write enable
// -----------------------------------------------------------------------------
module etapa_ex (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [2:0]  AluOP,
    input  logic        RegDsr,
    input  logic        RegWrite,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    input  logic [31:0] store_data,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [5:0]  funct,
    output logic        stall_out,
    output logic        valid_out,
    output logic [31:0] resultado,
    output logic [31:0] store_out,
    output logic [4:0]  reg_destino,
    output logic        RegWrite_out
);

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } mdu_state_t;

    mdu_state_t  state;
    mdu_state_t  next_state;
    logic [5:0]  count;
    logic [31:0] acc_hi;
    logic [31:0] acc_lo;
    logic [31:0] operand;
    logic [31:0] hi_reg;
    logic [31:0] lo_reg;
    logic        busy;

    logic [31:0] alu_result;
    logic        legal;
    logic        is_mul;
    logic        is_div;
    logic        is_md_funct;
    logic        accept;
    logic        start_mul;
    logic        start_div;
    logic [4:0]  dest;

    logic [32:0] mul_sum;
    logic [32:0] div_shifted;
    logic        div_ge;
    logic [31:0] step_hi;
    logic [31:0] step_lo;

    assign busy = (state != IDLE);

    // Operation decode. multu/divu are legal instructions but never write the
    // register file, so they leave legal at 0 and only flag the unit start.
    always_comb begin
        alu_result = 32'd0;
        legal      = 1'b0;
        is_mul     = 1'b0;
        is_div     = 1'b0;
        case (AluOP)
            3'b000: begin alu_result = data1 + data2; legal = 1'b1; end
            3'b001: begin alu_result = data1 - data2; legal = 1'b1; end
            3'b010: begin
                case (funct)
                    FN_ADD:   begin alu_result = data1 + data2; legal = 1'b1; end
                    FN_SUB:   begin alu_result = data1 - data2; legal = 1'b1; end
                    FN_AND:   begin alu_result = data1 & data2; legal = 1'b1; end
                    FN_OR:    begin alu_result = data1 | data2; legal = 1'b1; end
                    FN_SLT:   begin
                        alu_result = {31'd0, $signed(data1) < $signed(data2)};
                        legal      = 1'b1;
                    end
                    FN_MULTU: is_mul = 1'b1;
                    FN_DIVU:  is_div = 1'b1;
                    FN_MFHI:  begin alu_result = hi_reg; legal = 1'b1; end
                    FN_MFLO:  begin alu_result = lo_reg; legal = 1'b1; end
                    default:  begin alu_result = 32'd0; legal = 1'b0; end
                endcase
            end
            3'b011: begin alu_result = data1 & data2; legal = 1'b1; end
            3'b100: begin alu_result = data1 | data2; legal = 1'b1; end
            3'b101: begin
                alu_result = {31'd0, $signed(data1) < $signed(data2)};
                legal      = 1'b1;
            end
            3'b110: begin alu_result = {data2[15:0], 16'd0}; legal = 1'b1; end
            default: begin alu_result = 32'd0; legal = 1'b0; end
        endcase
    end

    assign is_md_funct = (funct == FN_MULTU) || (funct == FN_DIVU) ||
                         (funct == FN_MFHI)  || (funct == FN_MFLO);

    // Only instructions that touch the mul/div unit wait for it; a second
    // multu/divu is held here, so an in-flight operation is never overwritten.
    assign stall_out = valid_in & busy & is_md_funct & (AluOP == 3'b010);
    assign accept    = valid_in & ~stall_out;
    assign start_mul = accept & is_mul;
    assign start_div = accept & is_div;
    assign dest      = RegDsr ? rd : rt;

    // One shift-add multiply step: multiplier bits are consumed from acc_lo[0]
    // while product bits shift in from the top, so {acc_hi,acc_lo} ends as the
    // 64-bit product after 32 steps.
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : 33'd0);

    // One restoring divide step. The partial remainder is always below the
    // divisor, so after the subtraction it fits in 32 bits. A zero divisor
    // always "fits", which yields an all-ones quotient and HI = dividend.
    assign div_shifted = {acc_hi, acc_lo[31]};
    assign div_ge      = (div_shifted >= {1'b0, operand});

    always_comb begin
        step_hi = acc_hi;
        step_lo = acc_lo;
        case (state)
            MUL: begin
                step_hi = mul_sum[32:1];
                step_lo = {mul_sum[0], acc_lo[31:1]};
            end
            DIV: begin
                step_hi = div_ge ? (div_shifted[31:0] - operand) : div_shifted[31:0];
                step_lo = {acc_lo[30:0], div_ge};
            end
            default: begin
                step_hi = acc_hi;
                step_lo = acc_lo;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start_mul) begin
                    next_state = MUL;
                end else if (start_div) begin
                    next_state = DIV;
                end
            end
            MUL, DIV: begin
                if (count == 6'd1) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // Unit datapath. HI/LO only change on the final step, so mfhi/mflo never
    // observe a half-finished result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= 6'd0;
            acc_hi  <= 32'd0;
            acc_lo  <= 32'd0;
            operand <= 32'd0;
            hi_reg  <= 32'd0;
            lo_reg  <= 32'd0;
        end else if (state == IDLE) begin
            if (start_mul) begin
                acc_hi  <= 32'd0;
                acc_lo  <= data2;
                operand <= data1;
                count   <= 6'd32;
            end else if (start_div) begin
                acc_hi  <= 32'd0;
                acc_lo  <= data1;
                operand <= data2;
                count   <= 6'd32;
            end
        end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            count  <= count - 6'd1;
            if (count == 6'd1) begin
                hi_reg <= step_hi;
                lo_reg <= step_lo;
            end
        end
    end

    // EX/MEM register. Stalled or empty slots become full bubbles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out    <= 1'b0;
            RegWrite_out <= 1'b0;
            resultado    <= 32'd0;
            store_out    <= 32'd0;
            reg_destino  <= 5'd0;
        end else if (!accept) begin
            valid_out    <= 1'b0;
            RegWrite_out <= 1'b0;
            resultado    <= 32'd0;
            store_out    <= 32'd0;
            reg_destino  <= 5'd0;
        end else begin
            valid_out    <= 1'b1;
            RegWrite_out <= RegWrite & legal & (dest != 5'd0);
            resultado    <= alu_result;
            store_out    <= store_data;
            reg_destino  <= dest;
        end
    end

endmodule

// File: tb/tb_etapa_ex.sv
// -----------------------------------------------------------------------------
// tb_etapa_ex -- self-checking bench for etapa_ex.
//
// Every accepted instruction pushes its expected EX/MEM word, tagged with the
// cycle it must appear in, onto a scoreboard queue. A monitor on the falling
// edge pops and compares it, and expects a full bubble in every other cycle.
// HI/LO are modelled with native 64-bit multiply, divide and modulo.
// -----------------------------------------------------------------------------
module tb_etapa_ex;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_AND   = 6'b100100;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_MULTU = 6'b011001;
    localparam logic [5:0] FN_DIVU  = 6'b011011;
    localparam logic [5:0] FN_MFHI  = 6'b010000;
    localparam logic [5:0] FN_MFLO  = 6'b010010;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [2:0]  AluOP;
    logic        RegDsr;
    logic        RegWrite;
    logic [31:0] data1;
    logic [31:0] data2;
    logic [31:0] store_data;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic        stall_out;
    logic        valid_out;
    logic [31:0] resultado;
    logic [31:0] store_out;
    logic [4:0]  reg_destino;
    logic        RegWrite_out;

    typedef struct {
        int          due;
        logic [70:0] word;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_item;
    logic [70:0] mon_exp;
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    logic        mon_en = 1'b0;
    logic [31:0] model_hi = 32'd0;
    logic [31:0] model_lo = 32'd0;
    int          st;

    etapa_ex dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .AluOP        (AluOP),
        .RegDsr       (RegDsr),
        .RegWrite     (RegWrite),
        .data1        (data1),
        .data2        (data2),
        .store_data   (store_data),
        .rt           (rt),
        .rd           (rd),
        .funct        (funct),
        .stall_out    (stall_out),
        .valid_out    (valid_out),
        .resultado    (resultado),
        .store_out    (store_out),
        .reg_destino  (reg_destino),
        .RegWrite_out (RegWrite_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [70:0] got, input logic [70:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s got=%h expected=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference behaviour of one instruction. HI/LO reads use the model state.
    function automatic void refModel(input logic [2:0] op, input logic [5:0] fn,
                                     input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] res, output logic legal);
        res   = 32'd0;
        legal = 1'b1;
        case (op)
            3'b000: res = a + b;
            3'b001: res = a - b;
            3'b011: res = a & b;
            3'b100: res = a | b;
            3'b101: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b110: res = b << 16;
            3'b111: legal = 1'b0;
            default: begin
                if (fn == FN_ADD)       res = a + b;
                else if (fn == FN_SUB)  res = a - b;
                else if (fn == FN_AND)  res = a & b;
                else if (fn == FN_OR)   res = a | b;
                else if (fn == FN_SLT)  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                else if (fn == FN_MFHI) res = model_hi;
                else if (fn == FN_MFLO) res = model_lo;
                else                    legal = 1'b0;
            end
        endcase
    endfunction

    // Presents one instruction and holds it until EX accepts it. Returns the
    // number of cycles it spent stalled.
    task automatic applyStimulus(input logic [2:0] op, input logic [5:0] fn,
                                 input logic dsr, input logic wr,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] sd, input logic [4:0] rt_v,
                                 input logic [4:0] rd_v, output int stalls);
        logic        done;
        logic [31:0] res;
        logic        legal;
        logic [4:0]  dest;
        logic        wexp;
        logic [63:0] prod;
        exp_t        item;
        AluOP      = op;
        funct      = fn;
        RegDsr     = dsr;
        RegWrite   = wr;
        data1      = a;
        data2      = b;
        store_data = sd;
        rt         = rt_v;
        rd         = rd_v;
        valid_in   = 1'b1;
        stalls     = 0;
        done       = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (stall_out) begin
                stalls++;
            end else begin
                refModel(op, fn, a, b, res, legal);
                dest      = dsr ? rd_v : rt_v;
                wexp      = wr & legal & (dest != 5'd0);
                item.due  = cyc + 1;
                item.word = {1'b1, wexp, dest, sd, res};
                sb.push_back(item);
                if (op == 3'b010 && fn == FN_MULTU) begin
                    prod     = {32'd0, a} * {32'd0, b};
                    model_hi = prod[63:32];
                    model_lo = prod[31:0];
                end else if (op == 3'b010 && fn == FN_DIVU) begin
                    if (b == 32'd0) begin
                        model_lo = 32'hFFFF_FFFF;
                        model_hi = a;
                    end else begin
                        model_lo = a / b;
                        model_hi = a % b;
                    end
                end
                done = 1'b1;
            end
            @(posedge clk);
            #1;
            if (done) break;
        end
        if (!done) checkOutput("stall_timeout", 71'd1, 71'd0);
        valid_in = 1'b0;
    endtask

    task automatic idleCycles(input int n);
        valid_in = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // EX/MEM monitor: scheduled entries must appear exactly on their cycle,
    // every other cycle must be a full bubble.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && mon_en) begin
            mon_exp = 71'd0;
            if (sb.size() > 0 && sb[0].due == cyc) begin
                mon_item = sb.pop_front();
                mon_exp  = mon_item.word;
            end
            checkOutput("exmem", {valid_out, RegWrite_out, reg_destino, store_out, resultado}, mon_exp);
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst_n      = 1'b0;
        valid_in   = 1'b0;
        AluOP      = 3'd0;
        RegDsr     = 1'b0;
        RegWrite   = 1'b0;
        data1      = 32'd0;
        data2      = 32'd0;
        store_data = 32'd0;
        rt         = 5'd0;
        rd         = 5'd0;
        funct      = 6'd0;
        #23;
        checkOutput("reset_exmem", {valid_out, RegWrite_out, reg_destino, store_out, resultado}, 71'd0);
        checkOutput("reset_stall", {70'd0, stall_out}, 71'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Plain ALU operations, one per cycle.
        applyStimulus(3'b000, 6'd0, 1'b1, 1'b1, 32'd5, 32'd7, 32'h0000_AAAA, 5'd2, 5'd3, st);
        applyStimulus(3'b001, 6'd0, 1'b1, 1'b1, 32'd3, 32'd5, 32'd1, 5'd2, 5'd4, st);
        applyStimulus(3'b101, 6'd0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd1, 32'd2, 5'd2, 5'd5, st);
        applyStimulus(3'b110, 6'd0, 1'b0, 1'b1, 32'd0, 32'h0000_1234, 32'd3, 5'd6, 5'd0, st);
        applyStimulus(3'b011, 6'd0, 1'b0, 1'b1, 32'hF0F0_FFFF, 32'h0FF0_00FF, 32'd4, 5'd7, 5'd0, st);
        applyStimulus(3'b100, 6'd0, 1'b0, 1'b1, 32'hF000_0000, 32'h0000_000F, 32'd5, 5'd8, 5'd0, st);
        applyStimulus(3'b010, FN_ADD, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd6, 5'd1, 5'd10, st);
        applyStimulus(3'b010, FN_SUB, 1'b1, 1'b1, 32'd100, 32'd1, 32'd7, 5'd1, 5'd11, st);
        applyStimulus(3'b010, FN_AND, 1'b1, 1'b1, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd8, 5'd1, 5'd12, st);
        applyStimulus(3'b010, FN_OR,  1'b1, 1'b1, 32'h1200_0000, 32'h0000_0034, 32'd9, 5'd1, 5'd13, st);
        applyStimulus(3'b010, FN_SLT, 1'b1, 1'b1, 32'd1, 32'hFFFF_FFFF, 32'd10, 5'd1, 5'd14, st);
        applyStimulus(3'b010, FN_SLT, 1'b1, 1'b1, 32'h8000_0000, 32'd0, 32'd11, 5'd1, 5'd15, st);
        applyStimulus(3'b111, 6'd0, 1'b1, 1'b1, 32'd9, 32'd9, 32'd12, 5'd1, 5'd16, st);
        applyStimulus(3'b010, 6'b000111, 1'b1, 1'b1, 32'd9, 32'd9, 32'd13, 5'd1, 5'd17, st);
        idleCycles(2);

        // Destination selection and $0 suppression.
        applyStimulus(3'b000, 6'd0, 1'b1, 1'b1, 32'd1, 32'd1, 32'd14, 5'd9, 5'd0, st);
        applyStimulus(3'b000, 6'd0, 1'b0, 1'b1, 32'd1, 32'd2, 32'd15, 5'd9, 5'd20, st);
        applyStimulus(3'b000, 6'd0, 1'b0, 1'b0, 32'd1, 32'd3, 32'd16, 5'd9, 5'd20, st);

        // multu followed immediately by mflo / mfhi.
        applyStimulus(3'b010, FN_MULTU, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'd2, 32'd17, 5'd0, 5'd0, st);
        checkOutput("multu_issue_stalls", 71'(st), 71'd0);
        applyStimulus(3'b010, FN_MFLO, 1'b1, 1'b1, 32'd0, 32'd0, 32'd18, 5'd0, 5'd21, st);
        checkOutput("mflo_stalls", 71'(st), 71'd32);
        applyStimulus(3'b010, FN_MFHI, 1'b1, 1'b1, 32'd0, 32'd0, 32'd19, 5'd0, 5'd22, st);
        checkOutput("mfhi_stalls", 71'(st), 71'd0);

        // divu, including divide by zero.
        applyStimulus(3'b010, FN_DIVU, 1'b1, 1'b1, 32'd100, 32'd7, 32'd20, 5'd0, 5'd0, st);
        applyStimulus(3'b010, FN_MFLO, 1'b1, 1'b1, 32'd0, 32'd0, 32'd21, 5'd0, 5'd23, st);
        checkOutput("divu_mflo_stalls", 71'(st), 71'd32);
        applyStimulus(3'b010, FN_MFHI, 1'b1, 1'b1, 32'd0, 32'd0, 32'd22, 5'd0, 5'd24, st);
        applyStimulus(3'b010, FN_DIVU, 1'b1, 1'b1, 32'd5, 32'd0, 32'd23, 5'd0, 5'd0, st);
        applyStimulus(3'b010, FN_MFLO, 1'b1, 1'b1, 32'd0, 32'd0, 32'd24, 5'd0, 5'd25, st);
        applyStimulus(3'b010, FN_MFHI, 1'b1, 1'b1, 32'd0, 32'd0, 32'd25, 5'd0, 5'd26, st);

        // Independent work overlaps a busy multu; a second multu waits.
        applyStimulus(3'b010, FN_MULTU, 1'b1, 1'b1, 32'd3, 32'd4, 32'd26, 5'd0, 5'd0, st);
        applyStimulus(3'b000, 6'd0, 1'b1, 1'b1, 32'd40, 32'd2, 32'd27, 5'd0, 5'd27, st);
        checkOutput("indep_add_stalls", 71'(st), 71'd0);
        applyStimulus(3'b010, FN_MULTU, 1'b1, 1'b1, 32'h0001_0000, 32'h0001_0000, 32'd28, 5'd0, 5'd0, st);
        checkOutput("multu2_stalls", 71'(st), 71'd31);
        applyStimulus(3'b010, FN_MFLO, 1'b1, 1'b1, 32'd0, 32'd0, 32'd29, 5'd0, 5'd28, st);
        checkOutput("multu2_mflo_stalls", 71'(st), 71'd32);
        applyStimulus(3'b010, FN_MFHI, 1'b1, 1'b1, 32'd0, 32'd0, 32'd30, 5'd0, 5'd29, st);

        // Reset ten cycles into a divu.
        applyStimulus(3'b010, FN_DIVU, 1'b1, 1'b1, 32'd100, 32'd7, 32'd31, 5'd0, 5'd0, st);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(3'b000, 6'd0, 1'b1, 1'b1, 32'(i + 1), 32'd50, 32'(i + 100), 5'd0, 5'd30, st);
        end
        AluOP    = 3'b010;
        funct    = FN_MFHI;
        RegDsr   = 1'b1;
        RegWrite = 1'b1;
        rd       = 5'd31;
        valid_in = 1'b1;
        #1;
        checkOutput("busy_stall", {70'd0, stall_out}, 71'd1);
        #1;
        rst_n = 1'b0;
        #1;
        checkOutput("midop_reset_exmem", {valid_out, RegWrite_out, reg_destino, store_out, resultado}, 71'd0);
        checkOutput("midop_reset_stall", {70'd0, stall_out}, 71'd0);
        valid_in = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        sb.delete();
        model_hi = 32'd0;
        model_lo = 32'd0;
        rst_n    = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(3'b010, FN_MFHI, 1'b1, 1'b1, 32'd0, 32'd0, 32'd32, 5'd0, 5'd31, st);
        checkOutput("post_reset_mfhi_stalls", 71'(st), 71'd0);
        applyStimulus(3'b010, FN_MFLO, 1'b1, 1'b1, 32'd0, 32'd0, 32'd33, 5'd0, 5'd30, st);
        idleCycles(3);
        checkOutput("scoreboard_drained", 71'(sb.size()), 71'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/etapa_ex.md
# etapa_ex

Execute stage of the pipelined MIPS core, directly downstream of the ID/EX pipeline register. It decodes the ALU operation from the ALU opcode and funct field, computes the result, and selects the destination register. It registers everything into the EX/MEM boundary. It also contains a 32-cycle iterative unsigned multiply/divide unit with HI/LO registers, and raises a combinational stall toward the upstream stages while a dependent instruction waits on that unit.

## Interface
Parameters: none (datapath fixed at 32 bits, register index at 5 bits).
- clk  in  1  pipeline clock, all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- valid_in  in  1  ID/EX holds a real instruction (0 = bubble)
- AluOP  in  3  ALU opcode from ID/EX
- RegDsr  in  1  destination select: 1 = rd, 0 = rt
- RegWrite  in  1  instruction writes the register file
- data1  in  32  operand A (rs value)
- data2  in  32  operand B (rt value or sign-extended immediate)
- store_data  in  32  rt value passed through for stores
- rt  in  5  instruction bits [20:16]
- rd  in  5  instruction bits [15:11]
- funct  in  6  instruction bits [5:0]
- stall_out  out  1  combinational; freezes PC, IF/ID and ID/EX
- valid_out  out  1  EX/MEM holds a real instruction
- resultado  out  32  ALU / HI / LO result
- store_out  out  32  registered store_data
- reg_destino  out  5  selected destination register
- RegWrite_out  out  1  registered, qualified write enable

## Operation
- AluOP decode:
  - 000 add
  - 001 sub
  - 010 R-type (use funct)
  - 011 and
  - 100 or
  - 101 slt
  - 110 lui (data2 << 16)
  - 111 reserved: result 0, write suppressed
- R-type funct decode:
  - 100000 add; 100010 sub; 100100 and; 100101 or; 101010 slt
  - 011001 multu; 011011 divu
  - 010000 mfhi; 010010 mflo
  - Any other funct: result 0, write suppressed.
- Arithmetic rules:
  - add/sub wrap modulo 2^32 with no overflow trap.
  - slt is signed two's-complement and yields 0 or 1.
- Destination: reg_destino = RegDsr ? rd : rt.
  - RegWrite_out = RegWrite & valid & decoded-legal & (reg_destino != 0).
- multu/divu issue:
  - Loads operands into the unit, sets busy, and loads the count with 32.
  - Passes to EX/MEM as valid with RegWrite_out=0 and resultado=0.
- Unit states:
  - IDLE, MUL (shift-add), DIV (restoring).
  - Each cycle in MUL/DIV decrements the count.
  - When the count reaches 0 the unit writes HI/LO and returns to IDLE.
- multu result: {HI,LO} = 64-bit unsigned product.
- divu result: LO = quotient, HI = remainder.
  - Divide by zero: LO=32'hFFFFFFFF, HI=data1 (natural restoring result, no exception).
- mfhi/mflo write the current HI/LO to resultado.
- Interlock: stall_out = valid_in & busy & (funct is multu, divu, mfhi or mflo) & AluOP==010.
  - Independent instructions proceed while the unit is busy.
- EX/MEM bubble insertion: when stall_out=1 or valid_in=0, the next edge loads:
  - valid_out=0, RegWrite_out=0
  - resultado=0, reg_destino=0, store_out=0

## Timing
- Reset (async assert): all of the following clear immediately, independent of clk:
  - Outputs: valid_out, RegWrite_out, resultado, store_out, reg_destino all 0.
  - Unit state: HI=LO=0, busy=0, state IDLE, count=0.
- Reset mid-operation aborts the unit. HI/LO read 0 afterwards. stall_out is 0 while in reset.
- ALU path latency: 1 cycle (result visible after the edge that samples the ID/EX values).
- multu/divu:
  - Issue edge = E. busy=1 from E.
  - HI/LO final and busy=0 after edge E+32.
  - An mfhi sitting in EX stalls for cycles E..E+31 and is accepted at edge E+33, i.e. the first edge where busy=0 at the sampling point.
- Back-to-back multu: the second one stalls until busy=0, then issues. It never overwrites an in-flight operation.
- stall_out is purely combinational from valid_in, AluOP, funct and busy. There is no extra cycle of delay.
- An mfhi in the issue cycle of a multu cannot occur; program order guarantees the multu issues first.

## Test plan
- Reset then ALU ops: add 5+7 -> resultado=12; sub 3-5 -> 32'hFFFFFFFE; slt -1<1 -> 1; lui 16'h1234 -> 32'h12340000. All with 1-cycle latency.
- Destination / $0: RegDsr=1, rd=0, RegWrite=1 -> RegWrite_out=0. RegDsr=0, rt=9 -> reg_destino=9, RegWrite_out=1.
- multu 32'hFFFFFFFF x 2 followed immediately by mflo:
  - stall_out high exactly 32 cycles; EX/MEM shows bubbles.
  - mflo returns 32'hFFFFFFFE; a following mfhi returns 1.
- divu 100/7 -> LO=14, HI=2. divu 5/0 -> LO=32'hFFFFFFFF, HI=5.
- Independent add issued during a busy multu: no stall, correct result next cycle. A second multu stalls until busy clears.
- Assert rst_n low 10 cycles into a divu: outputs and HI/LO go to 0 immediately; stall_out=0; after release a fresh mfhi returns 0.
